// File: rtl/elevator.sv
// -----------------------------------------------------------------------------
// elevator -- four-floor (0..3) car controller.
//
// Calls from the hall/car buttons are latched into a pending register. The
// car serves them in its last travel direction, takes FLOOR_TICKS cycles per
// floor and dwells DWELL cycles with the door open at each served floor.
//
// Optional feature (compile-time macro ELEVATOR_FIRE_RECALL_EN):
//   fire recall. While firealarm is high, all calls are discarded and the car
//   returns to floor 0, where the door opens and stays open. When the alarm
//   clears, the car gives a normal door dwell. Without the macro, firealarm
//   is ignored.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   reqG..reqF3     call inputs for floors 0..3 (any width >= 1 clock)
//   overload        car overweight (level)
//   firealarm       building fire alarm (level)
//   person_detected doorway obstruction (level)
//   door_open       registered door-open indication
//   door_closed     inverse of door_open
//   bcd_floor       current floor in BCD (0..3)
//   seg             7-segment pattern {g,f,e,d,c,b,a}, active high
//   prox            current floor as a 2-bit binary number
// -----------------------------------------------------------------------------
module elevator (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqG,
  input  logic       reqF1,
  input  logic       reqF2,
  input  logic       reqF3,
  input  logic       overload,
  input  logic       firealarm,
  input  logic       person_detected,
  output logic       door_open,
  output logic       door_closed,
  output logic [3:0] bcd_floor,
  output logic [6:0] seg,
  output logic [1:0] prox
);

  localparam int unsigned FLOOR_TICKS = 4;
  localparam int unsigned DWELL       = 5;
  localparam logic [1:0]  TICK_LAST   = 2'(FLOOR_TICKS - 1);
  localparam logic [2:0]  DWELL_LAST  = 3'(DWELL - 1);

`ifdef ELEVATOR_FIRE_RECALL_EN
  typedef enum logic [2:0] {
    S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR, S_FIRE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR
  } state_t;
`endif

  // registers
  state_t      r_state;
  logic [1:0]  r_floor;
  logic [3:0]  r_pending;
  logic        r_dir;        // 1 = up (last travel direction)
  logic [1:0]  r_tick;       // cycles spent on the current floor hop
  logic [2:0]  r_dwell;      // door cycles remaining minus one
  logic        r_door_open;
  logic [6:0]  r_seg;

  // next-state wires
  state_t      w_state_nxt;
  logic [1:0]  w_floor_nxt;
  logic [3:0]  w_pend_nxt;
  logic        w_dir_nxt;
  logic [1:0]  w_tick_nxt;
  logic [2:0]  w_dwell_nxt;
  logic        w_door_nxt;

  logic [3:0]  w_req;
  logic [1:0]  w_floor_up;
  logic [1:0]  w_floor_dn;
  logic        w_tick_done;
  logic        w_above;
  logic        w_below;

`ifndef ELEVATOR_FIRE_RECALL_EN
  logic        w_unused_fire;
  assign w_unused_fire = firealarm;
`endif

  assign w_req       = {reqF3, reqF2, reqF1, reqG};
  assign w_floor_up  = r_floor + 2'd1;
  assign w_floor_dn  = r_floor - 2'd1;
  assign w_tick_done = (r_tick == TICK_LAST);

  function automatic logic any_above(input logic [3:0] p, input logic [1:0] f);
    any_above = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      if (2'(i) > f) any_above = any_above | p[i];
  endfunction

  function automatic logic any_below(input logic [3:0] p, input logic [1:0] f);
    any_below = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      if (2'(i) < f) any_below = any_below | p[i];
  endfunction

  function automatic logic [6:0] seg_of(input logic [1:0] f);
    case (f)
      2'd0:    seg_of = 7'b0111111;
      2'd1:    seg_of = 7'b0000110;
      2'd2:    seg_of = 7'b1011011;
      default: seg_of = 7'b1001111;
    endcase
  endfunction

  assign w_above = any_above(r_pending, r_floor);
  assign w_below = any_below(r_pending, r_floor);

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_pend_nxt  = r_pending | w_req;
    w_dir_nxt   = r_dir;
    w_tick_nxt  = '0;
    w_dwell_nxt = r_dwell;

    case (r_state)
      S_IDLE: begin
        if (r_pending[r_floor]) begin
          w_state_nxt = S_DOOR;
          w_dwell_nxt = DWELL_LAST;
        end else if (!overload) begin
          // with calls on both sides, keep going the way we last went
          if (w_above && (r_dir || !w_below)) begin
            w_state_nxt = S_MOVE_UP;
            w_dir_nxt   = 1'b1;
          end else if (w_below) begin
            w_state_nxt = S_MOVE_DOWN;
            w_dir_nxt   = 1'b0;
          end
        end
      end

      S_MOVE_UP: begin
        if (r_floor == 2'd3) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick_done) begin
          w_floor_nxt = w_floor_up;
          if (w_pend_nxt[w_floor_up]) begin
            w_state_nxt = S_DOOR;
            w_dwell_nxt = DWELL_LAST;
          end else if (!any_above(w_pend_nxt, w_floor_up)) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_tick_nxt = r_tick + 2'd1;
        end
      end

      S_MOVE_DOWN: begin
        if (r_floor == 2'd0) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick_done) begin
          w_floor_nxt = w_floor_dn;
          if (w_pend_nxt[w_floor_dn]) begin
            w_state_nxt = S_DOOR;
            w_dwell_nxt = DWELL_LAST;
          end else if (!any_below(w_pend_nxt, w_floor_dn)) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_tick_nxt = r_tick + 2'd1;
        end
      end

      S_DOOR: begin
        // overload keeps reloading, which holds the door open indefinitely
        if (overload || person_detected || w_req[r_floor]) begin
          w_dwell_nxt = DWELL_LAST;
        end else if (r_dwell == 3'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dwell_nxt = r_dwell - 3'd1;
        end
      end

`ifdef ELEVATOR_FIRE_RECALL_EN
      S_FIRE: begin
        if (!firealarm) begin
          if (r_floor == 2'd0) begin
            w_state_nxt = S_DOOR;
            w_dwell_nxt = DWELL_LAST;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_floor != 2'd0) begin
          if (w_tick_done) begin
            w_floor_nxt = w_floor_dn;
            w_dir_nxt   = 1'b0;
          end else begin
            w_tick_nxt = r_tick + 2'd1;
          end
        end
      end
`endif

      default: w_state_nxt = S_IDLE;
    endcase

    // the call at the floor where the door is (re)opening is served
    if (w_state_nxt == S_DOOR) w_pend_nxt[w_floor_nxt] = 1'b0;

`ifdef ELEVATOR_FIRE_RECALL_EN
    // alarm overrides everything: drop calls, freeze position, start recall
    if (firealarm) begin
      w_pend_nxt = '0;
      if (r_state != S_FIRE) begin
        w_state_nxt = S_FIRE;
        w_floor_nxt = r_floor;
        w_tick_nxt  = '0;
      end
    end
    w_door_nxt = (w_state_nxt == S_DOOR) ||
                 ((w_state_nxt == S_FIRE) && (w_floor_nxt == 2'd0));
`else
    w_door_nxt = (w_state_nxt == S_DOOR);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_floor     <= '0;
      r_pending   <= '0;
      r_dir       <= 1'b1;
      r_tick      <= '0;
      r_dwell     <= '0;
      r_door_open <= 1'b0;
      r_seg       <= 7'b0111111;
    end else begin
      r_state     <= w_state_nxt;
      r_floor     <= w_floor_nxt;
      r_pending   <= w_pend_nxt;
      r_dir       <= w_dir_nxt;
      r_tick      <= w_tick_nxt;
      r_dwell     <= w_dwell_nxt;
      r_door_open <= w_door_nxt;
      r_seg       <= seg_of(w_floor_nxt);
    end
  end

  assign door_open   = r_door_open;
  assign door_closed = ~r_door_open;
  assign bcd_floor   = {2'b00, r_floor};
  assign prox        = r_floor;
  assign seg         = r_seg;

endmodule

// File: tb/tb_elevator.sv
module tb_elevator;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       overload;
  logic       firealarm;
  logic       person_detected;
  logic       door_open;
  logic       door_closed;
  logic [3:0] bcd_floor;
  logic [6:0] seg;
  logic [1:0] prox;

  elevator dut (
    .clk             (clk),
    .rst             (rst),
    .reqG            (req[0]),
    .reqF1           (req[1]),
    .reqF2           (req[2]),
    .reqF3           (req[3]),
    .overload        (overload),
    .firealarm       (firealarm),
    .person_detected (person_detected),
    .door_open       (door_open),
    .door_closed     (door_closed),
    .bcd_floor       (bcd_floor),
    .seg             (seg),
    .prox            (prox)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         fl;
    int         lat;
    logic [1:0] prox;
    logic [3:0] bcd;
    logic [6:0] seg;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;
  int   n;
  exp_t tbl [5];
  exp_t sb [$];
  exp_t e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_open(input int c0, output int c);
    c = c0;
    while (door_open !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_close(output int c);
    c = 0;
    while (door_open === 1'b1 && c < 100) begin
      tick();
      c++;
    end
  endtask

  task automatic serve(input int f, output int c);
    req[f] = 1'b1;
    tick();
    req = '0;
    wait_open(1, c);
  endtask

  task automatic pop_chk(input string nm);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_prox"}, 32'(prox), 32'(e.prox));
      chk({nm, "_bcd"}, 32'(bcd_floor), 32'(e.bcd));
      chk({nm, "_seg"}, 32'(seg), 32'(e.seg));
      chk({nm, "_door_closed"}, 32'(door_closed), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3, 14, 2'd3, 4'd3, 7'b1001111};
    tbl[1] = '{1, 10, 2'd1, 4'd1, 7'b0000110};
    tbl[2] = '{2,  6, 2'd2, 4'd2, 7'b1011011};
    tbl[3] = '{2,  2, 2'd2, 4'd2, 7'b1011011};
    tbl[4] = '{0, 10, 2'd0, 4'd0, 7'b0111111};

    rst = 1'b0;
    req = '0;
    overload = 1'b0;
    firealarm = 1'b0;
    person_detected = 1'b0;

    // asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_door_open", 32'(door_open), 32'd0);
    chk("rst_door_closed", 32'(door_closed), 32'd1);
    chk("rst_bcd", 32'(bcd_floor), 32'd0);
    chk("rst_seg", 32'(seg), 32'b0111111);
    chk("rst_prox", 32'(prox), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // table-driven trips: latency, floor display, dwell length
    for (int i = 0; i < 5; i++) begin
      sb.push_back(tbl[i]);
      serve(tbl[i].fl, cyc);
      chk($sformatf("trip%0d_lat", i), cyc, tbl[i].lat);
      pop_chk($sformatf("trip%0d", i));
      wait_close(n);
      chk($sformatf("trip%0d_dwell", i), n, 32'd5);
      chk($sformatf("trip%0d_closed", i), 32'(door_closed), 32'd1);
    end

    // obstruction reloads the dwell (car at floor 1)
    serve(1, cyc);
    chk("pd_lat", cyc, 32'd6);
    person_detected = 1'b1;
    tick();
    tick();
    person_detected = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("pd_open%0d", k), 32'(door_open), 32'd1);
    end
    tick();
    chk("pd_closed", 32'(door_closed), 32'd1);

    // overload during door: held open, then normal dwell, no motion
    serve(1, cyc);
    chk("ovd_lat", cyc, 32'd2);
    overload = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ovd_hold%0d", k), 32'(door_open), 32'd1);
    end
    overload = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ovd_rel%0d", k), 32'(door_open), 32'd1);
    end
    tick();
    chk("ovd_closed", 32'(door_closed), 32'd1);
    chk("ovd_prox", 32'(prox), 32'd1);

    // overload in idle blocks departure
    overload = 1'b1;
    req[2] = 1'b1;
    tick();
    req = '0;
    repeat (10) tick();
    chk("ovi_prox", 32'(prox), 32'd1);
    chk("ovi_closed", 32'(door_closed), 32'd1);
    overload = 1'b0;
    wait_open(0, cyc);
    chk("ovi_lat", cyc, 32'd5);
    chk("ovi_dest", 32'(prox), 32'd2);
    wait_close(n);

    // up to 3, then G and F2 called: serve 2 first, then 0
    serve(3, cyc);
    chk("up3_lat", cyc, 32'd6);
    wait_close(n);
    sb.push_back(tbl[2]);
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    sb.push_back(tbl[4]);
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    wait_open(0, cyc);
    pop_chk("dn_first");
    wait_close(n);
    wait_open(0, cyc);
    pop_chk("dn_second");
    wait_close(n);
    repeat (12) tick();
    chk("dn_rest_prox", 32'(prox), 32'd0);
    chk("dn_rest_closed", 32'(door_closed), 32'd1);

    // fire alarm at floor 2 with a call for 3
    serve(2, cyc);
    chk("fire_pre_lat", cyc, 32'd10);
    wait_close(n);
    firealarm = 1'b1;
    req[3] = 1'b1;
    tick();
    req = '0;
`ifdef ELEVATOR_FIRE_RECALL_EN
    wait_open(1, cyc);
    chk("fire_lat", cyc, 32'd9);
    chk("fire_prox", 32'(prox), 32'd0);
    overload = 1'b1;
    person_detected = 1'b1;
    repeat (3) tick();
    chk("fire_hold", 32'(door_open), 32'd1);
    overload = 1'b0;
    person_detected = 1'b0;
    firealarm = 1'b0;
    wait_close(n);
    chk("fire_dwell", n, 32'd6);
    repeat (12) tick();
    chk("fire_discard_prox", 32'(prox), 32'd0);
    chk("fire_discard_closed", 32'(door_closed), 32'd1);
`else
    wait_open(1, cyc);
    chk("nofire_lat", cyc, 32'd6);
    chk("nofire_prox", 32'(prox), 32'd3);
    wait_close(n);
    chk("nofire_dwell", n, 32'd5);
    firealarm = 1'b0;
`endif

    // reset mid-move between floors 1 and 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req[3] = 1'b1;
    tick();
    req = '0;
    cyc = 0;
    while (prox !== 2'd1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("mid_reach1", 32'(prox), 32'd1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_door_open", 32'(door_open), 32'd0);
    chk("mid_rst_door_closed", 32'(door_closed), 32'd1);
    chk("mid_rst_bcd", 32'(bcd_floor), 32'd0);
    chk("mid_rst_seg", 32'(seg), 32'b0111111);
    chk("mid_rst_prox", 32'(prox), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (14) tick();
    chk("mid_after_prox", 32'(prox), 32'd0);
    chk("mid_after_closed", 32'(door_closed), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator.md
ELEVATOR -- requirements
Module: elevator

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 reqG, reqF1, reqF2, reqF3  input  1 each  hall/car call pulses for floors 0..3; any width of at least one clock.
REQ-004 overload  input  1  car overweight; level-sensitive.
REQ-005 firealarm  input  1  building fire alarm; level-sensitive.
REQ-006 person_detected  input  1  doorway obstruction sensor; level-sensitive.
REQ-007 door_open  output  1  door open indication, registered.
REQ-008 door_closed  output  1  always equals the inverse of door_open.
REQ-009 bcd_floor  output  4  current floor in BCD, 0..3, upper two bits always 0.
REQ-010 seg  output  7  active-high 7-segment pattern {g,f,e,d,c,b,a} of current floor.
REQ-011 prox  output  2  current car position, binary floor number 0..3.

Function
REQ-012 FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR, FIRE; fixed constants FLOOR_TICKS=4 cycles per floor and DWELL=5 cycles door-open time.
REQ-013 Each req input sets its bit in a 4-bit pending register on the clock edge where it is sampled high; a bit clears when the door opens at that floor.
REQ-014 IDLE: pending bit at current floor -> DOOR next edge; else pending above -> MOVE_UP; else pending below -> MOVE_DOWN; else stay IDLE.
REQ-015 When pending floors exist both above and below, the car continues in the last travel direction; the initial direction after reset is up.
REQ-016 MOVE_x: the floor changes by one every FLOOR_TICKS cycles; at arrival on a floor with a pending bit -> DOOR, otherwise continue; the floor never passes 0 or 3.
REQ-017 DOOR: door_open=1 and the dwell counter runs DWELL cycles, then door closes -> IDLE.
REQ-018 In DOOR, person_detected=1 or a new request for the current floor reloads the dwell counter.
REQ-019 overload=1 in DOOR holds the door open indefinitely (the counter is frozen at reload); overload=1 in IDLE blocks departure; overload has no effect while moving.
REQ-020 door_open=1 only in DOOR or FIRE-at-floor-0; the car never moves with door_open=1.
REQ-021 seg encodings: 0->0111111, 1->0000110, 2->1011011, 3->1001111.
REQ-022 bcd_floor, seg and prox update on the same edge as the floor register.

Reset
REQ-023 rst=1 forces, asynchronously: floor=0, state=IDLE, pending=0000, door_open=0, door_closed=1, bcd_floor=0000, seg=0111111, prox=00, direction=up.
REQ-024 Reset mid-travel discards motion and pending requests; there is no recovery of the previous position.

Configuration
REQ-025 Macro ELEVATOR_FIRE_RECALL_EN defined: firealarm=1 clears pending, ignores requests and enters FIRE, and the car travels down at FLOOR_TICKS per floor to floor 0 with the door closed.
REQ-026 In FIRE, once at floor 0 the door opens and stays open regardless of overload/person_detected; when firealarm falls -> DOOR with a fresh dwell.
REQ-027 Macro not defined: the firealarm input is ignored and the FIRE state is not implemented.

Verification
REQ-028 rst pulse, then reqF3 high for 2 cycles -> prox steps 0->1->2->3 at 4-cycle intervals; at 3, door_open=1, bcd_floor=0011, seg=1001111.
REQ-029 At floor 3 with door open, person_detected high for 2 cycles -> door stays open until 5 cycles after person_detected falls, then door_closed=1.
REQ-030 reqG then reqF2 while the car is at floor 3 -> the car goes to 2 first (direction down), opens, then continues to 0 and opens; pending=0000 at the end.
REQ-031 overload=1 during DOOR at floor 1 for 4 cycles -> door_open remains 1 the whole time plus 5 cycles after release; prox is unchanged.
REQ-032 With ELEVATOR_FIRE_RECALL_EN, firealarm=1 at floor 2 with reqF3 pending -> the car goes to 0, door_open=1 while the alarm is high, and reqF3 is discarded; without the macro, the same stimulus serves floor 3.
REQ-033 rst asserted mid-move between floors 1 and 2 -> all outputs reach reset values immediately, without waiting for a clock edge.
